// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe skid stage: state encoding, counter width
// and the occupancy decode used by the stage.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

    localparam int STALL_CNT_W = 16;

    function automatic logic [1:0] occupancy_of(input skid_state_e state);
        logic [1:0] occ;
        occ = 2'd0;
        case (state)
            ONE:     occ = 2'd1;
            TWO:     occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// Two-entry skid pipeline stage with a registered out_data and a state-only in_ready.
// Optional back-pressure counter on stall_cnt, enabled by PIPE_SKID_STALL_CNT_EN.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int                 DATA_W   = 32,
    parameter logic [DATA_W-1:0]  RST_DATA = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [1:0]             occupancy
`ifdef PIPE_SKID_STALL_CNT_EN
   ,output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    if (DATA_W < 1 || DATA_W > 1024) begin : g_bad_width
        $error("pipe_skid_stage: DATA_W must be within 1..1024");
    end

    skid_state_e       state_q;
    skid_state_e       state_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              load_main;
    logic              main_from_skid;
    logic              load_skid;
    logic              accept;
    logic              deliver;

    // Handshake decodes depend on state only, so in_ready never combinationally follows out_ready.
    assign in_ready  = (state_q == EMPTY) || (state_q == ONE);
    assign out_valid = (state_q == ONE) || (state_q == TWO);
    assign occupancy = occupancy_of(state_q);
    assign out_data  = main_q;
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush only forces the state to EMPTY; the data registers are left untouched.
    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        load_main = 1'b1;
                        state_d   = ONE;
                    end
                end
                ONE: begin
                    if (accept && deliver) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        state_d   = TWO;
                    end else if (deliver) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (deliver) begin
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                        state_d        = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= RST_DATA;
            skid_q <= '0;
        end else begin
            if (load_main) begin
                main_q <= main_from_skid ? skid_q : in_data;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

`ifdef PIPE_SKID_STALL_CNT_EN
    // Saturating count of cycles a live entry waits on the consumer; only rst clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed steps on a 32-bit instance,
// then randomized traffic on 1-bit and 128-bit instances against a queue model.
module tb_pipe_skid_stage;

    localparam logic [31:0]  RST32  = 32'h5A5A_A5A5;
    localparam logic [127:0] RST128 = {4{32'hF00D_CAFE}};
    localparam int           RAND_CYCLES = 10000;

    logic clk;
    logic rst;

    logic         v32, r32, f32, ir32, ov32;
    logic [31:0]  d32, od32;
    logic [1:0]   occ32;

    logic         v1, r1, f1, ir1, ov1, d1, od1;
    logic [1:0]   occ1;

    logic         v128, r128, f128, ir128, ov128;
    logic [127:0] d128, od128;
    logic [1:0]   occ128;

`ifdef PIPE_SKID_STALL_CNT_EN
    logic [15:0]  sc32, sc1, sc128;
    logic [15:0]  stall_m;
`endif

    int compared;
    int mismatched;

    logic [31:0]  q32[$];
    logic         q1[$];
    logic [127:0] q128[$];

    pipe_skid_stage #(.DATA_W(32), .RST_DATA(RST32)) dut (
        .clk(clk), .rst(rst), .flush(f32),
        .in_valid(v32), .in_ready(ir32), .in_data(d32),
        .out_valid(ov32), .out_ready(r32), .out_data(od32),
        .occupancy(occ32)
`ifdef PIPE_SKID_STALL_CNT_EN
       ,.stall_cnt(sc32)
`endif
    );

    pipe_skid_stage #(.DATA_W(1)) dut_w1 (
        .clk(clk), .rst(rst), .flush(f1),
        .in_valid(v1), .in_ready(ir1), .in_data(d1),
        .out_valid(ov1), .out_ready(r1), .out_data(od1),
        .occupancy(occ1)
`ifdef PIPE_SKID_STALL_CNT_EN
       ,.stall_cnt(sc1)
`endif
    );

    pipe_skid_stage #(.DATA_W(128), .RST_DATA(RST128)) dut_w128 (
        .clk(clk), .rst(rst), .flush(f128),
        .in_valid(v128), .in_ready(ir128), .in_data(d128),
        .out_valid(ov128), .out_ready(r128), .out_data(od128),
        .occupancy(occ128)
`ifdef PIPE_SKID_STALL_CNT_EN
       ,.stall_cnt(sc128)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // The model is a FIFO of capacity two; flush empties it and drops the same-cycle input.
    task automatic applyStimulus(input logic v, input logic [31:0] d,
                                 input logic ordy, input logic fl);
        logic acc, del;
        v32 = v; d32 = d; r32 = ordy; f32 = fl;
        acc = v && (q32.size() < 2);
        del = (q32.size() > 0) && ordy;
`ifdef PIPE_SKID_STALL_CNT_EN
        if ((q32.size() > 0) && !ordy && (stall_m != 16'hFFFF)) stall_m++;
`endif
        if (fl) begin
            q32.delete();
        end else begin
            if (del) void'(q32.pop_front());
            if (acc) q32.push_back(d);
        end
        @(negedge clk);
        checkOutput("out_valid", ov32, q32.size() > 0);
        checkOutput("in_ready", ir32, q32.size() < 2);
        checkOutput("occupancy", occ32, q32.size());
        if (q32.size() > 0) checkOutput("out_data", od32, q32[0]);
`ifdef PIPE_SKID_STALL_CNT_EN
        checkOutput("stall_cnt", sc32, stall_m);
`endif
    endtask

    initial begin
        compared = 0; mismatched = 0;
        rst = 1'b1;
        v32 = 0; d32 = '0; r32 = 0; f32 = 0;
        v1 = 0; d1 = 0; r1 = 0; f1 = 0;
        v128 = 0; d128 = '0; r128 = 0; f128 = 0;
`ifdef PIPE_SKID_STALL_CNT_EN
        stall_m = 16'd0;
`endif
        #1;
        checkOutput("rst_out_valid", ov32, 1'b0);
        checkOutput("rst_in_ready", ir32, 1'b1);
        checkOutput("rst_occupancy", occ32, 2'd0);
        checkOutput("rst_out_data", od32, RST32);
        checkOutput("rst_out_data_w128", od128, RST128);
        checkOutput("rst_out_data_w1", od1, 1'b0);
`ifdef PIPE_SKID_STALL_CNT_EN
        checkOutput("rst_stall_cnt", sc32, 16'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] streaming");
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 32'(i), 1'b1, 1'b0);
            checkOutput("stream_data", od32, 32'(i));
            checkOutput("stream_occ", occ32, 2'd1);
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("stream_drained", ov32, 1'b0);

        $display("[TB] back-pressure");
        applyStimulus(1'b1, 32'hA, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hB, 1'b0, 1'b0);
        checkOutput("bp_occ", occ32, 2'd2);
        checkOutput("bp_in_ready", ir32, 1'b0);
        checkOutput("bp_head", od32, 32'hA);
        applyStimulus(1'b1, 32'hEE, 1'b1, 1'b0);
        checkOutput("bp_second", od32, 32'hB);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("bp_drained", ov32, 1'b0);

        $display("[TB] flush");
        applyStimulus(1'b1, 32'h1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h2, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hC, 1'b0, 1'b1);
        checkOutput("flush_out_valid", ov32, 1'b0);
        checkOutput("flush_occ", occ32, 2'd0);
        checkOutput("flush_in_ready", ir32, 1'b1);
        checkOutput("flush_data_kept", od32, 32'h1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("flush_no_C", ov32, 1'b0);

        $display("[TB] async reset");
        applyStimulus(1'b1, 32'h7, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h8, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        q32.delete();
        checkOutput("arst_out_valid", ov32, 1'b0);
        checkOutput("arst_out_data", od32, RST32);
        checkOutput("arst_in_ready", ir32, 1'b1);
        checkOutput("arst_occ", occ32, 2'd0);
`ifdef PIPE_SKID_STALL_CNT_EN
        stall_m = 16'd0;
        checkOutput("arst_stall_cnt", sc32, 16'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 32'h9, 1'b1, 1'b0);
        checkOutput("post_rst_data", od32, 32'h9);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

`ifdef PIPE_SKID_STALL_CNT_EN
        $display("[TB] stall counter saturation");
        applyStimulus(1'b1, 32'h33, 1'b0, 1'b0);
        v32 = 1'b0;
        repeat (70000) @(negedge clk);
        stall_m = 16'hFFFF;
        checkOutput("stall_sat", sc32, 16'hFFFF);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("stall_after_flush", sc32, 16'hFFFF);
`endif

        $display("[TB] random traffic on 1-bit and 128-bit instances");
        for (int c = 0; c < RAND_CYCLES; c++) begin
            logic acc, del;
            v1 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            d1 = 1'($urandom);
            f1 = ($urandom_range(0, 31) == 0);
            v128 = 1'($urandom_range(0, 1));
            r128 = 1'($urandom_range(0, 1));
            d128 = {$urandom, $urandom, $urandom, $urandom};
            f128 = ($urandom_range(0, 31) == 0);

            acc = v1 && (q1.size() < 2);
            del = (q1.size() > 0) && r1;
            if (f1) q1.delete();
            else begin
                if (del) void'(q1.pop_front());
                if (acc) q1.push_back(d1);
            end

            acc = v128 && (q128.size() < 2);
            del = (q128.size() > 0) && r128;
            if (f128) q128.delete();
            else begin
                if (del) void'(q128.pop_front());
                if (acc) q128.push_back(d128);
            end

            @(negedge clk);
            checkOutput("w1_out_valid", ov1, q1.size() > 0);
            checkOutput("w1_in_ready", ir1, q1.size() < 2);
            checkOutput("w1_occ", occ1, q1.size());
            if (q1.size() > 0) checkOutput("w1_out_data", od1, q1[0]);
            checkOutput("w128_out_valid", ov128, q128.size() > 0);
            checkOutput("w128_in_ready", ir128, q128.size() < 2);
            checkOutput("w128_occ", occ128, q128.size());
            if (q128.size() > 0) checkOutput("w128_out_data", od128, q128[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
